// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern ROM readers.
package led_pattern_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      LAT,
      CAPTURE,
      HOLD
   } state_t;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 4;

   localparam logic DIR_INC = 1'b0;
   localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/led_step_timer.sv
// Slow-rate step timer: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
module led_step_timer #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tc = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_reader.sv
// Read-side sequencer for the LED pattern ROMs: steps the address every TICK_DIV cycles, latches data onto led.
// Build option LED_PATTERN_READER_BOUNCE_EN: address ping-pongs between 0 and the top word instead of wrapping.
//
// state   | meaning
// IDLE    | ROM disabled, led held, waiting for run
// ISSUE   | ROM enabled, address presented
// LAT     | extra cycle for a registered-output ROM (READ_LAT=2 only)
// CAPTURE | ROM data valid; led loaded and address stepped at the closing edge
// HOLD    | ROM disabled, waiting out the step timer
module led_pattern_reader
   import led_pattern_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int TICK_DIV   = 50000000,
   parameter int READ_LAT   = 1,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              dir,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] led,
   output logic              step_pulse,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);

   state_t            state;
   logic              tick_tc;
   logic [ADDR_W-1:0] addr_next;

   led_step_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_step_timer (
      .clk (clk),
      .rst (rst),
      .clr ((state != HOLD) || !run),
      .en  ((state == HOLD) && run),
      .tc  (tick_tc)
   );

`ifdef LED_PATTERN_READER_BOUNCE_EN
   logic dir_q;
   logic dir_next;

   // Turn around on the end word so the address never leaves 0..2**ADDR_W-1.
   always_comb begin
      dir_next = dir_q;
      if ((dir_q == DIR_INC) && (rom_addr == '1)) begin
         dir_next = DIR_DEC;
      end else if ((dir_q == DIR_DEC) && (rom_addr == '0)) begin
         dir_next = DIR_INC;
      end
      addr_next = (dir_next == DIR_INC) ? rom_addr + ADDR_W'(1) : rom_addr - ADDR_W'(1);
   end
`else
   assign addr_next = (dir == DIR_INC) ? rom_addr + ADDR_W'(1) : rom_addr - ADDR_W'(1);
`endif

   // rom_en doubles as the ROM set/reset release, so it must stay high from ISSUE through CAPTURE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rom_en     <= 1'b0;
         rom_addr   <= START_A;
         led        <= '0;
         step_pulse <= 1'b0;
         busy       <= 1'b0;
`ifdef LED_PATTERN_READER_BOUNCE_EN
         dir_q      <= dir;
`endif
      end else begin
         step_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (run) begin
                  state  <= ISSUE;
                  rom_en <= 1'b1;
                  busy   <= 1'b1;
`ifdef LED_PATTERN_READER_BOUNCE_EN
                  dir_q  <= dir;
`endif
               end
            end
            ISSUE: begin
               state <= (READ_LAT == 2) ? LAT : CAPTURE;
            end
            LAT: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               led        <= rom_data;
               step_pulse <= 1'b1;
               rom_addr   <= addr_next;
               rom_en     <= 1'b0;
               busy       <= 1'b0;
               state      <= run ? HOLD : IDLE;
`ifdef LED_PATTERN_READER_BOUNCE_EN
               dir_q      <= dir_next;
`endif
            end
            HOLD: begin
               if (!run) begin
                  state <= IDLE;
               end else if (tick_tc) begin
                  state  <= ISSUE;
                  rom_en <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               rom_en <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
